// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the branch condition, computes the next PC and
// registers the result behind a valid/ready handshake. Optional statistics counters
// are compiled in with the macro BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] DataA,
    input  logic [XLEN-1:0] DataB,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mispredict,
    output logic            illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] mispred_count
`endif
);

    logic            r_out_valid;
    logic            r_taken;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_mispredict;
    logic            r_illegal;

    logic            w_accept;
    logic            w_out_hs;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_cond;
    logic            w_illegal;
    logic            w_mispredict;
    logic [XLEN-1:0] w_target;

    // valid/ready: a transfer happens on any cycle where valid and ready are both high;
    // a held result stays stable until its consumer raises out_ready.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_out_hs = r_out_valid && out_ready;

    assign w_eq   = (DataA == DataB);
    assign w_lt_s = ($signed(DataA) < $signed(DataB));
    assign w_lt_u = (DataA < DataB);

    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_mispredict = !w_illegal && (w_cond ^ pred_taken);
    assign w_target     = w_cond ? (pc + imm) : (pc + XLEN'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_taken       <= 1'b0;
            r_redirect_pc <= '0;
            r_mispredict  <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_taken       <= w_cond;
                r_redirect_pc <= w_target;
                r_mispredict  <= w_mispredict;
                r_illegal     <= w_illegal;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign taken       = r_taken;
    assign redirect_pc = r_redirect_pc;
    assign mispredict  = r_mispredict;
    assign illegal     = r_illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_taken_count;
    logic [CNT_W-1:0] r_mispred_count;

    // Counters saturate at all-ones; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count      <= '0;
            r_taken_count   <= '0;
            r_mispred_count <= '0;
        end else if (stats_clr) begin
            r_br_count      <= '0;
            r_taken_count   <= '0;
            r_mispred_count <= '0;
        end else if (w_out_hs) begin
            if (r_br_count != {CNT_W{1'b1}})
                r_br_count <= r_br_count + CNT_W'(1);
            if (r_taken && (r_taken_count != {CNT_W{1'b1}}))
                r_taken_count <= r_taken_count + CNT_W'(1);
            if (r_mispredict && (r_mispred_count != {CNT_W{1'b1}}))
                r_mispred_count <= r_mispred_count + CNT_W'(1);
        end
    end

    assign br_count      = r_br_count;
    assign taken_count   = r_taken_count;
    assign mispred_count = r_mispred_count;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, a behavioural
// reference model, a per-cycle compare process and literal spot checks.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic            mispred;
    logic [XLEN-1:0] rpc;
  } res_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] data_a = '0;
  logic [XLEN-1:0] data_b = '0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] imm = '0;
  logic            pred_taken = 1'b0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            taken;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;
  logic            illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] mispred_count;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .DataA(data_a), .DataB(data_b), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .redirect_pc(redirect_pc),
    .mispredict(mispredict), .illegal(illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .stats_clr(stats_clr), .br_count(br_count), .taken_count(taken_count),
    .mispred_count(mispred_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: branch rules stated directly
  function automatic res_t resolve(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                                   input logic [XLEN-1:0] off, input logic pt);
    res_t r;
    r = '0;
    case (f3)
      3'd0: r.taken = (a == b);
      3'd1: r.taken = (a != b);
      3'd4: r.taken = ($signed(a) < $signed(b));
      3'd5: r.taken = ($signed(a) >= $signed(b));
      3'd6: r.taken = (a < b);
      3'd7: r.taken = (a >= b);
      default: r.illegal = 1'b1;
    endcase
    r.rpc = r.taken ? p + off : p + 32'd4;
    r.mispred = r.illegal ? 1'b0 : (r.taken ^ pt);
    return r;
  endfunction

  logic exp_valid;
  res_t exp_res;
  res_t m_res;
  logic m_acc;
  logic m_hs;
  assign m_res = resolve(funct3, data_a, data_b, pc, imm, pred_taken);
  assign m_hs  = exp_valid && out_ready;
  assign m_acc = in_valid && (!exp_valid || out_ready) && !flush;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_res   <= '0;
    end else begin
      if (flush) exp_valid <= 1'b0;
      else if (m_acc) exp_valid <= 1'b1;
      else if (m_hs) exp_valid <= 1'b0;
      if (m_acc) exp_res <= m_res;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  int exp_br, exp_tk, exp_mp;
  localparam int CMAX = (1 << CNT_W) - 1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_br <= 0; exp_tk <= 0; exp_mp <= 0;
    end else if (stats_clr) begin
      exp_br <= 0; exp_tk <= 0; exp_mp <= 0;
    end else if (m_hs) begin
      if (exp_br < CMAX) exp_br <= exp_br + 1;
      if (exp_res.taken && exp_tk < CMAX) exp_tk <= exp_tk + 1;
      if (exp_res.mispred && exp_mp < CMAX) exp_mp <= exp_mp + 1;
    end
  end
`endif

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(!exp_valid || out_ready));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("taken", 64'(taken), 64'(exp_res.taken));
        chk("illegal", 64'(illegal), 64'(exp_res.illegal));
        chk("mispredict", 64'(mispredict), 64'(exp_res.mispred));
        chk("redirect_pc", 64'(redirect_pc), 64'(exp_res.rpc));
      end
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("br_count", 64'(br_count), 64'(exp_br));
      chk("taken_count", 64'(taken_count), 64'(exp_tk));
      chk("mispred_count", 64'(mispred_count), 64'(exp_mp));
`endif
    end
  end

  // driver: apply one cycle of inputs, return #1 after the capturing edge
  task automatic drive(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] off, input logic pt,
                       input logic iv, input logic ordy, input logic fl);
    funct3 = f3; data_a = a; data_b = b; pc = p; imm = off; pred_taken = pt;
    in_valid = iv; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_taken", 64'(taken), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_mispredict", 64'(mispredict), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // equal operands, predicted not-taken
    drive(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("v038_valid", 64'(out_valid), 64'd1);
    chk("v038_taken", 64'(taken), 64'd1);
    chk("v038_rpc", 64'(redirect_pc), 64'h120);
    chk("v038_mispred", 64'(mispredict), 64'd1);

    // signed vs unsigned less-than on the same operands
    drive(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("v039_signed_taken", 64'(taken), 64'd1);
    drive(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("v039_unsigned_taken", 64'(taken), 64'd0);
    chk("v039_unsigned_rpc", 64'(redirect_pc), 64'h204);

    // PC wrap-around in both directions
    drive(3'd1, 32'd3, 32'd4, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("v041_taken_wrap", 64'(redirect_pc), 64'h4);
    drive(3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("v041_fall_wrap", 64'(redirect_pc), 64'h0);
    chk("v041_fall_mispred", 64'(mispredict), 64'd1);

    // unsupported condition, then flush drops the next request
    drive(3'd2, 32'd7, 32'd7, 32'h300, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("v042_illegal", 64'(illegal), 64'd1);
    chk("v042_taken", 64'(taken), 64'd0);
    chk("v042_mispred", 64'(mispredict), 64'd0);
    chk("v042_rpc", 64'(redirect_pc), 64'h304);
    drive(3'd0, 32'd1, 32'd1, 32'h400, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("v042_flush_valid", 64'(out_valid), 64'd0);
    idle(1);

    // back-pressure for two cycles, then back-to-back results
    drive(3'd0, 32'd9, 32'd9, 32'h500, 32'h30, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(3'd1, 32'd1, 32'd2, 32'h600, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("v040_stall_ready", 64'(in_ready), 64'd0);
    chk("v040_stall_rpc", 64'(redirect_pc), 64'h530);
    drive(3'd1, 32'd1, 32'd2, 32'h600, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("v040_stall2_rpc", 64'(redirect_pc), 64'h530);
    drive(3'd1, 32'd1, 32'd2, 32'h600, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("v040_b2b1_valid", 64'(out_valid), 64'd1);
    chk("v040_b2b1_rpc", 64'(redirect_pc), 64'h640);
    drive(3'd7, 32'd1, 32'd2, 32'h700, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("v040_b2b2_valid", 64'(out_valid), 64'd1);
    chk("v040_b2b2_rpc", 64'(redirect_pc), 64'h704);
    idle(2);

    // mixed directed sweep, checked every cycle by the model
    for (int i = 0; i < 60; i++) begin
      logic [XLEN-1:0] a, b;
      a = 32'($urandom_range(0, 3));
      b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
      if ($urandom_range(0, 1) == 1) b = b | 32'h8000_0000;
      drive(3'($urandom_range(0, 7)), a, b, 32'($urandom_range(0, 65535)) << 2,
            32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    idle(2);

`ifdef BRANCH_RESOLVE_STATS_EN
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    chk("v043_clr", 64'(br_count), 64'd0);
    for (int i = 0; i < 5; i++)
      drive(3'd0, 32'd1, 32'd1, 32'h800, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("v043_br_sat", 64'(br_count), 64'd3);
    chk("v043_taken_sat", 64'(taken_count), 64'd3);
    chk("v043_mispred_sat", 64'(mispred_count), 64'd3);
    drive(3'd0, 32'd1, 32'd1, 32'h800, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("v043_rst_valid", 64'(out_valid), 64'd0);
    chk("v043_rst_br", 64'(br_count), 64'd0);
    chk("v043_rst_taken", 64'(taken_count), 64'd0);
    chk("v043_rst_mispred", 64'(mispred_count), 64'd0);
`else
    drive(3'd0, 32'd1, 32'd1, 32'h800, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_rpc", 64'(redirect_pc), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
